// File: rtl/fp_normalize_pack_pkg.sv
// Shared types and constants for the adder back end (normalize, round, pack).
// Provides the FSM state type, the default field widths, the significand bit
// layout and fpPack, which assembles a binary32-style word from its fields.
package fp_normalize_pack_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;

  // Significand layout: carry | hidden | fraction | G | R | S
  localparam int SIG_W      = FP_FRAC_W + 5;
  localparam int EXP_MAX    = (1 << FP_EXP_W) - 1;
  localparam int SIG_CARRY  = FP_FRAC_W + 4;
  localparam int SIG_HIDDEN = FP_FRAC_W + 3;
  localparam int SIG_G      = 2;
  localparam int SIG_R      = 1;
  localparam int SIG_S      = 0;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} norm_state_t;

  // Inverse of fpUnpack: {sign, exponent field, fraction field}.
  function automatic logic [FP_EXP_W+FP_FRAC_W:0] fpPack(
    input logic                 s,
    input logic [FP_EXP_W-1:0]  e,
    input logic [FP_FRAC_W-1:0] f
  );
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_normalize_pack_round.sv
// Combinational round-to-nearest-even stage.
// Ports:
//   i_sig      hidden | fraction | G | R | S (already normalized, no carry)
//   i_exp      signed internal exponent
//   i_denorm   significand is denormal (exponent field will be 0 unless
//              rounding lifts it into the hidden bit)
//   i_zero     exact zero sum
//   o_frac     rounded fraction field
//   o_exp      exponent field after rounding / overflow to infinity
//   o_overflow, o_underflow, o_inexact, o_zero  status flags
module fp_round_rne #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic [FRAC_W+3:0]       i_sig,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic                    i_denorm,
  input  logic                    i_zero,
  output logic [FRAC_W-1:0]       o_frac,
  output logic [EXP_W-1:0]        o_exp,
  output logic                    o_overflow,
  output logic                    o_underflow,
  output logic                    o_inexact,
  output logic                    o_zero
);

  // Extra top bit catches the carry out of the hidden bit.
  localparam int MW = FRAC_W + 2;
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);

  logic                    w_lsb;
  logic                    w_g;
  logic                    w_r;
  logic                    w_s;
  logic                    w_inc;
  logic                    w_grs;
  logic [MW-1:0]           w_mant;
  logic signed [EXP_W+1:0] w_exp_rnd;

  assign w_lsb  = i_sig[3];
  assign w_g    = i_sig[2];
  assign w_r    = i_sig[1];
  assign w_s    = i_sig[0];
  assign w_grs  = w_g | w_r | w_s;
  // Nearest-even: round up above half, or at exactly half when LSB is odd.
  assign w_inc  = w_g & (w_r | w_s | w_lsb);
  assign w_mant = {1'b0, i_sig[FRAC_W+3:3]} + MW'(w_inc);

  always_comb begin
    o_frac      = '0;
    o_exp       = '0;
    o_overflow  = 1'b0;
    o_underflow = 1'b0;
    o_inexact   = 1'b0;
    o_zero      = 1'b0;
    w_exp_rnd   = i_exp;
    if (i_zero) begin
      o_zero = 1'b1;
    end else begin
      o_inexact = w_grs;
      if (w_mant[MW-1]) begin
        // Rounding overflowed 1.111..1 into 10.000..0: renormalize.
        o_frac    = w_mant[FRAC_W:1];
        w_exp_rnd = i_exp + (EXP_W+2)'(1);
      end else begin
        o_frac    = w_mant[FRAC_W-1:0];
      end
      if (i_denorm) begin
        // A denormal that rounds into the hidden bit becomes the smallest normal.
        o_exp  = {{(EXP_W-1){1'b0}}, w_mant[FRAC_W]};
        o_zero = ~w_mant[FRAC_W] & (o_frac == '0);
      end else if (w_exp_rnd >= EMAX) begin
        o_frac     = '0;
        o_exp      = '1;
        o_overflow = 1'b1;
        o_inexact  = 1'b1;
      end else begin
        o_exp = w_exp_rnd[EXP_W-1:0];
      end
      o_underflow = (i_denorm | o_zero) & o_inexact;
    end
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// Serial normalizer / rounder / packer for the adder datapath.
// Accepts a raw significand sum with GRS bits, normalizes one bit per cycle,
// rounds to nearest-even and presents a packed word plus flags.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       operand handshake (accepted only in IDLE)
//   sign_in, exp_in, sig_in   result sign, biased exponent, raw significand
//   out_valid / out_ready     result handshake; result held until taken
//   result                    {sign, exponent, fraction}
//   overflow, underflow, inexact, zero   status flags
module fp_normalize_pack
  import fp_normalize_pack_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int FRAC_W = FP_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign_in,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic [FRAC_W+4:0]       sig_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact,
  output logic                    zero
);

  localparam int L_SIG_W  = FRAC_W + 5;
  localparam int L_CARRY  = FRAC_W + 4;
  localparam int L_HIDDEN = FRAC_W + 3;
  localparam logic signed [EXP_W+1:0] L_EXP_ONE = (EXP_W+2)'(1);

  norm_state_t             r_state;
  norm_state_t             w_next;

  logic                    r_sign;
  logic signed [EXP_W+1:0] r_exp;
  logic [L_SIG_W-1:0]      r_sig;
  logic                    r_denorm;
  logic                    r_zero_in;

  logic [EXP_W+FRAC_W:0]   r_result;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    r_inexact;
  logic                    r_zero;

  logic                    w_sig_zero;
  logic                    w_carry;
  logic                    w_hidden;
  logic                    w_exp_gt1;

  logic [FRAC_W-1:0]       w_frac;
  logic [EXP_W-1:0]        w_exp_fld;
  logic                    w_ovf;
  logic                    w_unf;
  logic                    w_inx;
  logic                    w_zero;

  assign w_sig_zero = (r_sig == '0);
  assign w_carry    = r_sig[L_CARRY];
  assign w_hidden   = r_sig[L_HIDDEN];
  assign w_exp_gt1  = (r_exp > L_EXP_ONE);

  assign result    = r_result;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign inexact   = r_inexact;
  assign zero      = r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = NORM;
      NORM:    if (w_sig_zero || (!w_carry && (w_hidden || !w_exp_gt1))) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Capture / normalize: one shift per NORM cycle
  always_ff @(posedge clk) begin
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          r_sign    <= sign_in;
          r_exp     <= signed'({2'b00, exp_in});
          r_sig     <= sig_in;
          r_denorm  <= 1'b0;
          r_zero_in <= 1'b0;
        end
      end
      NORM: begin
        if (w_sig_zero) begin
          r_zero_in <= 1'b1;
        end else if (w_carry) begin
          // Bit falling off the bottom is folded into sticky.
          r_sig <= {1'b0, r_sig[L_SIG_W-1:2], r_sig[1] | r_sig[0]};
          r_exp <= r_exp + L_EXP_ONE;
        end else if (!w_hidden && w_exp_gt1) begin
          r_sig <= {r_sig[L_SIG_W-2:0], 1'b0};
          r_exp <= r_exp - L_EXP_ONE;
        end else if (!w_hidden) begin
          r_denorm <= 1'b1;
        end
      end
      default: ;
    endcase
  end

  fp_round_rne #(
    .EXP_W  (EXP_W),
    .FRAC_W (FRAC_W)
  ) u_round (
    .i_sig       (r_sig[L_HIDDEN:0]),
    .i_exp       (r_exp),
    .i_denorm    (r_denorm),
    .i_zero      (r_zero_in),
    .o_frac      (w_frac),
    .o_exp       (w_exp_fld),
    .o_overflow  (w_ovf),
    .o_underflow (w_unf),
    .o_inexact   (w_inx),
    .o_zero      (w_zero)
  );

  // Round / pack: result registered on leaving ROUND, held through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_inexact   <= 1'b0;
      r_zero      <= 1'b0;
    end else if (r_state == ROUND) begin
      // An exact zero sum is always +0; an underflow to zero keeps its sign.
      r_result    <= {r_sign & ~r_zero_in, w_exp_fld, w_frac};
      r_overflow  <= w_ovf;
      r_underflow <= w_unf;
      r_inexact   <= w_inx;
      r_zero      <= w_zero;
    end
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
module tb_fp_normalize_pack;
  import fp_normalize_pack_pkg::*;

  localparam int W = FP_EXP_W + FP_FRAC_W + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                sign_in = 1'b0;
  logic [FP_EXP_W-1:0] exp_in = '0;
  logic [SIG_W-1:0]    sig_in = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [W-1:0]        result;
  logic                overflow;
  logic                underflow;
  logic                inexact;
  logic                zero;

  fp_normalize_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .sig_in    (sig_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   fl;   // {overflow, underflow, inexact, zero}
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  bit           seen = 0;
  logic [W-1:0] held_res;
  logic [3:0]   held_fl;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("result", result, e.res);
          chk("flags", {overflow, underflow, inexact, zero}, e.fl);
          chk("latency", cyc - e.acc + 1, e.lat);
        end
        held_res = result;
        held_fl  = {overflow, underflow, inexact, zero};
        seen = 1;
      end else begin
        chk("hold_result", result, held_res);
        chk("hold_flags", {overflow, underflow, inexact, zero}, held_fl);
      end
      chk("in_ready_while_valid", in_ready, 0);
      if (out_ready) begin
        seen = 0;
        done_cnt++;
      end
    end
  end

  task automatic send(input logic s, input logic [7:0] e, input logic [SIG_W-1:0] sg,
                      input logic [W-1:0] er, input logic [3:0] fl, input int lat);
    exp_t x;
    int   t;
    int   target;
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_before_send", in_ready, 1);
    sign_in  = s;
    exp_in   = e;
    sig_in   = sg;
    in_valid = 1'b1;
    x.res = er; x.fl = fl; x.lat = lat; x.acc = cyc + 1;
    q.push_back(x);
    target = done_cnt + 1;
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (done_cnt < target && t < 200) begin @(negedge clk); t++; end
    chk("transaction_done", 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {overflow, underflow, inexact, zero}, 0);
    rst = 1'b0;

    // 1.0 + 1.0: carry only
    send(0, 8'd127, 28'h8000000, fpPack(0, 8'd128, 23'd0), 4'b0000, 4);
    // 1.5 already normalized
    send(0, 8'd127, 28'h6000000, 32'h3FC00000, 4'b0000, 3);
    // 1.0 - 0.75: two left shifts
    send(0, 8'd127, 28'h1000000, 32'h3E800000, 4'b0000, 5);
    // all-ones fraction + G: round carry renormalizes
    send(0, 8'd127, 28'h7FFFFFC, 32'h40000000, 4'b0010, 3);
    // tie, even LSB: no increment
    send(0, 8'd127, 28'h4000004, 32'h3F800000, 4'b0010, 3);
    // tie, odd LSB: increment
    send(0, 8'd127, 28'h400000C, fpPack(0, 8'd127, 23'd2), 4'b0010, 3);
    // negative 1.5
    send(1, 8'd127, 28'h6000000, 32'hBFC00000, 4'b0000, 3);
    // carry shift pushes fraction LSB into G, rounds up
    send(0, 8'd127, 28'h8000018, fpPack(0, 8'd128, 23'd2), 4'b0010, 4);
    // overflow to infinity
    send(0, 8'd254, 28'h8000000, 32'h7F800000, 4'b1010, 4);
    // exact zero with sign 1 -> +0
    send(1, 8'd127, 28'h0000000, 32'h00000000, 4'b0001, 3);
    // exact denormal
    send(0, 8'd1, 28'h2000000, 32'h00400000, 4'b0000, 3);
    // denormal rounds up into hidden bit
    send(0, 8'd1, 28'h3FFFFFC, 32'h00800000, 4'b0110, 3);
    // left shift stops at exponent 1
    send(0, 8'd2, 28'h1000000, 32'h00400000, 4'b0000, 4);
    // denormal underflows to -0
    send(1, 8'd1, 28'h0000004, 32'h80000000, 4'b0111, 3);

    // Backpressure: hold out_ready low for 5 valid cycles
    out_ready = 1'b0;
    fork
      send(0, 8'd127, 28'h6000000, 32'h3FC00000, 4'b0000, 3);
      begin
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // Reset during NORM abandons the operand
    @(negedge clk);
    sign_in = 0; exp_in = 8'd127; sig_in = 28'h1000000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no_output_after_abort", out_valid, 0);
    end

    // Operand after reset
    send(0, 8'd127, 28'h1000000, 32'h3E800000, 4'b0000, 5);

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
Back end of the single-precision adder datapath, downstream of compare_exponents/swap/align/add. It takes the raw, un-normalized significand sum with guard/round/sticky bits, the result exponent and the sign. It normalizes serially, one bit per cycle, rounds to nearest-even and packs an IEEE-754 binary32 word with status flags. It does the reverse of fpUnpack and hands results off over a valid/ready handshake.

Parameters:
EXP_W, 8, exponent field width
FRAC_W, 23, fraction field width
BIAS, 127, exponent bias (informational; max exponent is 2**EXP_W-1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand presented
in_ready  output  1  block can accept an operand
sign_in  input  1  result sign
exp_in  input  EXP_W  biased exponent from compare_exponents (exp_r)
sig_in  input  FRAC_W+5  [FRAC_W+4]=carry, [FRAC_W+3]=hidden, [FRAC_W+2:3]=fraction, [2]=G, [1]=R, [0]=S
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  EXP_W+FRAC_W+1  packed {sign, exponent, fraction}
overflow  output  1  result rounded to infinity
underflow  output  1  result is denormal/zero and inexact
inexact  output  1  any discarded bit was nonzero
zero  output  1  result magnitude is zero

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; in_ready=1; out_valid=0; result=0; all flags=0. Reset mid-operation abandons the operand with no output.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, capture sign/exp/sig into registers. The internal exponent is EXP_W+2 bits and signed. Go to NORM.
- NORM, one action per cycle, with this priority:
  - sig==0: go to ROUND with zero result.
  - carry=1: shift right by 1, OR the shifted-out bit into S, exp+1, stay in NORM.
  - hidden=0 and exp>1: shift left by 1 (S shifts into R, 0 into S), exp-1, stay in NORM.
  - hidden=0 and exp<=1: denormal, exponent field=0, go to ROUND.
  - otherwise go to ROUND.
- ROUND: round-to-nearest-even. Increment when G & (R|S|LSB). inexact=G|R|S.
  - Increment carries out of the hidden bit: shift right, exp+1.
  - Denormal rounds up into the hidden bit: exponent field becomes 1.
  - exp>=2**EXP_W-1 after rounding: result=±infinity (fraction 0), overflow=1, inexact=1.
  - underflow = (denormal or zero) & inexact.
  - Exact zero sum: result=+0 (sign forced to 0), zero=1.
  - Go to DONE.
- DONE: out_valid=1. result and flags are held stable until out_valid&out_ready, then return to IDLE. The next operand is not accepted in that same cycle.
- Latency from the accept edge to out_valid:
  - normalized input: 3 cycles
  - +1 for a carry
  - +1 per left shift (maximum FRAC_W+1 left shifts)
  - zero input: 3 cycles
- Each left shift needs exp>1, so exp can never fall below 1.
- in_ready=0 in NORM, ROUND and DONE. in_valid is ignored outside IDLE.

Decomposition:
- addpkg additions:
  - norm_state_t enum {IDLE, NORM, ROUND, DONE}
  - SIG_W = FRAC_W+5
  - constants EXP_MAX and the carry/hidden/G/R/S bit positions
  - fpPack function, the inverse of fpUnpack, for bench checking
- One combinational sub-module, fp_round_rne: takes the normalized significand, GRS and exponent; returns the rounded fraction, exponent and flags. It is instantiated in ROUND.

Test Plan:
- 1.0+1.0: sign 0, exp 127, sig carry-only -> result 0x40000000, no flags, out_valid 4 cycles after accept.
- 1.5 normalized: exp 127, hidden=1, fraction MSB=1 -> 0x3FC00000, latency 3.
- Cancellation 1.0-0.75: exp 127, sig with only bit FRAC_W+1 set -> 2 left shifts, 0x3E800000, latency 5.
- Rounding: exp 127, hidden and fraction all ones, G=1 -> round-carry renormalizes to 0x40000000, inexact=1. Tie case: fraction LSB=0, G=1, R=S=0 -> no increment, inexact=1.
- Overflow and zero: exp 254 with carry -> 0x7F800000, overflow=inexact=1. sig=0, sign=1 -> 0x00000000, zero=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
  - Assert rst during NORM -> out_valid never rises, in_ready=1 immediately.
  - A new operand after reset is processed correctly.
